mem_responder: RTL and testbench

- Word-addressed memory responder: the target end of the processor's fetch/data memory interface.
- Accepts one read or write request at a time over a req/ready handshake and inserts a programmable number of wait states.
- Returns read data with a one-cycle ack pulse.
- Sits between the processor core (initiator) and the on-chip RAM array. Also used by the program loader to write instruction images.

---
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (core or loader) and mem_responder.
// parity_inject exists only when MEM_PARITY_EN is defined.
interface mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] q;
  logic              err;
`ifdef MEM_PARITY_EN
  logic              parity_inject;

  modport master (output req, we, address, wdata, parity_inject,
                  input  ready, ack, q, err);
  modport slave  (input  req, we, address, wdata, parity_inject,
                  output ready, ack, q, err);
`else
  modport master (output req, we, address, wdata,
                  input  ready, ack, q, err);
  modport slave  (input  req, we, address, wdata,
                  output ready, ack, q, err);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target: one request at a time, WAIT_CYCLES wait states, one-cycle ack.
// Optional macro MEM_PARITY_EN: stores an even-parity bit per word and flags mismatches on read.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input logic            CLOCK_50,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] q_q;
`ifdef MEM_PARITY_EN
  logic              inject_q;
`endif

  logic [WORD_W-1:0] ram [DEPTH];

  // The array is looked up on the edge that enters RESP, so q is already valid with ack.
  // In IDLE that edge can be the accepting one (WAIT_CYCLES=0), hence the live-bus mux.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_we;
  logic              rd_in_range;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              resp_err;
  logic              enter_resp;
  logic [WORD_W-1:0] wr_word;

  always_comb begin
    rd_addr     = (state == ST_IDLE) ? bus.address : addr_q;
    rd_we       = (state == ST_IDLE) ? bus.we : we_q;
    rd_in_range = 32'(rd_addr) < DEPTH;
    rd_word     = ram[rd_addr[IDX_W-1:0]];
    rd_data     = rd_in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef MEM_PARITY_EN
    resp_err    = !rd_in_range || (!rd_we && (^rd_word));
    wr_word     = {(^wdata_q) ^ inject_q, wdata_q};
`else
    resp_err    = !rd_in_range;
    wr_word     = wdata_q;
`endif
    enter_resp  = (state == ST_IDLE && bus.req && WAIT_CYCLES == 0) ||
                  (state == ST_WAIT && cnt == '0);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      q_q     <= '0;
`ifdef MEM_PARITY_EN
      inject_q <= 1'b0;
`endif
    end else begin
      ack_q <= enter_resp;
      err_q <= enter_resp && resp_err;
      if (enter_resp && !rd_we) q_q <= rd_data;

      unique case (state)
        ST_IDLE: if (bus.req) begin
          we_q    <= bus.we;
          addr_q  <= bus.address;
          wdata_q <= bus.wdata;
`ifdef MEM_PARITY_EN
          inject_q <= bus.parity_inject;
`endif
          cnt     <= WAIT_LOAD;
          state   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM and keeps
  // its contents (e.g. a loaded program image) across a processor reset.
  always_ff @(posedge CLOCK_50) begin
    if (state == ST_RESP && we_q && rd_in_range) ram[addr_q[IDX_W-1:0]] <= wr_word;
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.q     = q_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table on a WAIT_CYCLES=2/DEPTH=2048 instance,
// plus hand-written sequences for reset abort, WAIT_CYCLES=0 back-to-back and parity.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifa ();
  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifb ();

  mem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(2048), .WAIT_CYCLES(2)) dut_a (
    .CLOCK_50(clk), .reset(rst_n), .bus(ifa));
  mem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_CYCLES(0)) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .bus(ifb));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_q;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic txn_a(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                       output logic [15:0] q, output logic err, output int lat);
    int guard = 0;
    while (!ifa.ready && guard < 50) begin @(negedge clk); guard++; end
    ifa.req = 1'b1; ifa.we = we; ifa.address = addr; ifa.wdata = wdata;
    @(negedge clk);
    ifa.req = 1'b0;
    lat = 1;
    while (!ifa.ack && lat < 50) begin @(negedge clk); lat++; end
    q = ifa.q; err = ifa.err;
    @(negedge clk);
  endtask

  task automatic txn_b(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                       output logic [15:0] q, output logic err, output int lat);
    int guard = 0;
    while (!ifb.ready && guard < 50) begin @(negedge clk); guard++; end
    ifb.req = 1'b1; ifb.we = we; ifb.address = addr; ifb.wdata = wdata;
    @(negedge clk);
    ifb.req = 1'b0;
    lat = 1;
    while (!ifb.ack && lat < 50) begin @(negedge clk); lat++; end
    q = ifb.q; err = ifb.err;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q;
    logic        err;
    int          lat;
    logic        saw_ack;

    // Expected q on a write is whatever the last read left there.
    vecs.push_back('{1'b1, 12'h005, 16'hBEEF, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 12'h005, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b1, 12'h006, 16'h1234, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b0, 12'h006, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 12'h005, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b0, 12'h900, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 12'h100, 16'h0F0F, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 12'h900, 16'h5555, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 12'h100, 16'h0000, 16'h0F0F, 1'b0});
    vecs.push_back('{1'b1, 12'h7FF, 16'hA5A5, 16'h0F0F, 1'b0});
    vecs.push_back('{1'b0, 12'h7FF, 16'h0000, 16'hA5A5, 1'b0});
    vecs.push_back('{1'b0, 12'h800, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 12'h010, 16'h0AAA, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 12'h010, 16'h0000, 16'h0AAA, 1'b0});

    ifa.req = 1'b0; ifa.we = 1'b0; ifa.address = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.address = '0; ifb.wdata = '0;
`ifdef MEM_PARITY_EN
    ifa.parity_inject = 1'b0;
    ifb.parity_inject = 1'b0;
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset ready", ifa.ready, 1'b1);
    check("reset ack",   ifa.ack,   1'b0);
    check("reset q",     ifa.q,     16'h0000);
    check("reset err",   ifa.err,   1'b0);
    check("reset b ready", ifb.ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, q, err, lat);
      check($sformatf("v%0d latency", i), lat, 3);
      check($sformatf("v%0d q", i), q, vecs[i].exp_q);
      check($sformatf("v%0d err", i), err, vecs[i].exp_err);
    end

    // Reset during WAIT of a write: the write must never land.
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.address = 12'h010; ifa.wdata = 16'h1111;
    @(negedge clk);
    ifa.req = 1'b0;
    check("abort ready in wait", ifa.ready, 1'b0);
    rst_n = 1'b0;
    saw_ack = 1'b0;
    repeat (3) begin @(negedge clk); saw_ack |= ifa.ack; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); saw_ack |= ifa.ack; end
    check("abort no ack", saw_ack, 1'b0);
    check("abort ready", ifa.ready, 1'b1);
    check("abort q cleared", ifa.q, 16'h0000);
    txn_a(1'b0, 12'h010, 16'h0000, q, err, lat);
    check("abort readback", q, 16'h0AAA);
    check("abort readback err", err, 1'b0);

    // WAIT_CYCLES=0 instance: seed two words, then back-to-back reads with req held high.
    txn_b(1'b1, 12'h000, 16'h1111, q, err, lat);
    check("b wr0 latency", lat, 1);
    txn_b(1'b1, 12'hFFF, 16'h2222, q, err, lat);
    check("b wrF latency", lat, 1);
    check("b wr q unchanged", q, 16'h0000);
    ifb.req = 1'b1; ifb.we = 1'b0; ifb.address = 12'h000;
    @(negedge clk);
    check("b2b ack1", ifb.ack, 1'b1);
    check("b2b ready1 low", ifb.ready, 1'b0);
    check("b2b q1", ifb.q, 16'h1111);
    ifb.address = 12'hFFF;
    @(negedge clk);
    check("b2b gap ack", ifb.ack, 1'b0);
    check("b2b gap ready", ifb.ready, 1'b1);
    check("b2b gap q held", ifb.q, 16'h1111);
    @(negedge clk);
    check("b2b ack2", ifb.ack, 1'b1);
    check("b2b ready2 low", ifb.ready, 1'b0);
    check("b2b q2", ifb.q, 16'h2222);
    check("b2b err2", ifb.err, 1'b0);
    ifb.req = 1'b0;
    @(negedge clk);
    check("b2b end ack", ifb.ack, 1'b0);
    check("b2b end ready", ifb.ready, 1'b1);

`ifdef MEM_PARITY_EN
    ifa.parity_inject = 1'b1;
    txn_a(1'b1, 12'h020, 16'h00FF, q, err, lat);
    ifa.parity_inject = 1'b0;
    txn_a(1'b0, 12'h020, 16'h0000, q, err, lat);
    check("parity bad q", q, 16'h00FF);
    check("parity bad err", err, 1'b1);
    txn_a(1'b1, 12'h020, 16'h00FF, q, err, lat);
    check("parity good wr err", err, 1'b0);
    txn_a(1'b0, 12'h020, 16'h0000, q, err, lat);
    check("parity good q", q, 16'h00FF);
    check("parity good err", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
